osd_vram_arbiter: RTL and testbench
===================================

# osd_vram_arbiter

Shares the single OSD character-RAM write port (v_we / v_wr_addr / v_wr_data) between NREQ independent writers (osd_writer instances, JVS log printers, status panels). Arbitration is round-robin with one write per cycle. An optional built-in bulk-clear engine fills the whole screen with one character. Sits between the OSD writers and the dual-port character RAM read by the video overlay.

## Interface
- NREQ, 4: number of requesters (2..8)
- COLS, 40: characters per row
- ROWS, 30: character rows
- ADDR_W, 16: VRAM address width
- DATA_W, 8: character code width

- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- req_valid  in  NREQ  per-requester write request
- req_ready  out  NREQ  per-requester accept; transfer when valid & ready
- req_addr  in  NREQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  NREQ*DATA_W  packed character codes
- clear_start  in  1  single-cycle pulse, begins full-screen clear
- clear_char  in  DATA_W  fill character, sampled with clear_start
- clear_busy  out  1  clear engine active
- grant_id  out  $clog2(NREQ)  index of last accepted requester
- err_oob  out  1  sticky: an out-of-range address was accepted
- v_we  out  1  VRAM write enable
- v_wr_addr  out  ADDR_W  VRAM write address
- v_wr_data  out  DATA_W  VRAM write data

## Operation
- Requesters hold valid, addr and data stable until ready. Dropping valid before ready is illegal.
- req_ready is combinational and one-hot or zero:
  - it is given to the first valid requester searching from (last_grant+1) mod NREQ upward;
  - it is forced to zero while clear_busy is high or clear_start is high.
- last_grant and grant_id update only on a handshake. With no handshake, the priority pointer holds.
- Accepted write with addr < COLS*ROWS: registered onto v_we / v_wr_addr / v_wr_data.
- Accepted write with addr >= COLS*ROWS:
  - it is consumed (ready given) but no v_we is issued;
  - err_oob sets and stays set until rst.
- Clear engine FSM states:
  - IDLE to CLEAR on clear_start. clear_char is latched at that point.
  - CLEAR writes addresses 0..COLS*ROWS-1 in order, one per cycle.
  - CLEAR returns to IDLE after the last address.
- clear_start while in CLEAR is ignored.
- Cell counter width is $clog2(COLS*ROWS). It never wraps: the terminal count ends CLEAR.
- Reset mid-clear aborts immediately and the FSM returns to IDLE. Cells already written stay written.

## Timing
- Reset values: v_we=0, v_wr_addr=0, v_wr_data=0, req_ready=0, clear_busy=0, grant_id=0, err_oob=0, last_grant=NREQ-1 (so requester 0 has first priority).
- Handshake in cycle N gives v_we=1 with that addr/data in cycle N+1. v_we is a single cycle per write.
- A continuously valid requester set gets back-to-back acceptance, one per cycle, rotating in index order.
- clear_start sampled in cycle N:
  - clear_busy is high in cycles N+1..N+COLS*ROWS;
  - v_we writes address k in cycle N+1+k;
  - clear_busy is low in cycle N+1+COLS*ROWS, and req_ready may assert in that same cycle.
- clear_start and req_valid in the same cycle: clear wins, and no request is accepted in cycle N.

## Configuration
- OSD_VRAM_ARBITER_CLEAR_EN defined: the clear engine is built as described above.
- OSD_VRAM_ARBITER_CLEAR_EN undefined:
  - the clear engine is not built;
  - clear_start and clear_char are ignored, and clear_busy is tied 0;
  - the port list is unchanged.

## Structure
- Package osd_pkg holds:
  - OSD_COLS=40, OSD_ROWS=30, OSD_CELLS=OSD_COLS*OSD_ROWS;
  - typedef osd_wr_t = struct {addr, data};
  - the clear FSM enum {CLR_IDLE, CLR_RUN}.
- Sub-module osd_rr_arbiter: parameter N, inputs req[N] and ptr, outputs a one-hot grant and the grant index. It is purely combinational, instantiated once.

## Test plan
- Fairness: requesters 0 and 2 held valid, with addr 0x10 data 0x41 and addr 0x20 data 0x42 respectively → accepts alternate 0,2,0,2 every cycle; v_we writes 0x10/0x41 then 0x20/0x42 each one cycle after its handshake.
- Pointer hold: only requester 3 valid, then only requester 1 valid → grant_id 3, then 1; no idle cycle between the two acceptances.
- Out of range: requester 1 addr 1200 (0x04B0) → req_ready[1] pulses, v_we stays 0, err_oob=1 until rst.
- Clear: clear_start with clear_char 0x20, requester 0 valid throughout → 1200 consecutive v_we cycles, addresses 0..1199 with data 0x20; req_ready=0 throughout; requester 0 accepted in the cycle clear_busy falls.
- Reset mid-clear: rst at clear cycle 500 → v_we=0 and clear_busy=0 the next cycle; a new clear_start afterwards restarts at address 0.
- Macro undefined: clear_start pulse → clear_busy stays 0, requests continue uninterrupted.

Source files
------------

// File: rtl/osd_pkg.sv
// Shared OSD definitions: screen geometry, write record and clear-engine states.
package osd_pkg;
    localparam int OSD_COLS   = 40;
    localparam int OSD_ROWS   = 30;
    localparam int OSD_CELLS  = OSD_COLS * OSD_ROWS;
    localparam int OSD_ADDR_W = 16;
    localparam int OSD_DATA_W = 8;

    typedef struct packed {
        logic [OSD_ADDR_W-1:0] addr;
        logic [OSD_DATA_W-1:0] data;
    } osd_wr_t;

    typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;
endpackage

// File: rtl/osd_rr_arbiter.sv
// Combinational round-robin picker: first asserted request searching upward
// from (ptr+1) mod N, returned as a one-hot grant plus its index.
module osd_rr_arbiter
    import osd_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);
    localparam int IW = $clog2(N);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/osd_vram_arbiter.sv
// Round-robin sharing of the OSD character-RAM write port between NREQ writers.
// Define OSD_VRAM_ARBITER_CLEAR_EN to build the full-screen bulk-clear engine.
module osd_vram_arbiter
    import osd_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int COLS   = OSD_COLS,
    parameter int ROWS   = OSD_ROWS,
    parameter int ADDR_W = OSD_ADDR_W,
    parameter int DATA_W = OSD_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic                     clear_start,
    input  logic [DATA_W-1:0]        clear_char,
    output logic                     clear_busy,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     err_oob,
    output logic                     v_we,
    output logic [ADDR_W-1:0]        v_wr_addr,
    output logic [DATA_W-1:0]        v_wr_data
);
    localparam int                CELLS   = COLS * ROWS;
    localparam int                GW      = $clog2(NREQ);
    localparam logic [ADDR_W-1:0] CELLS_A = ADDR_W'(CELLS);

    logic [GW-1:0]     last_grant;
    logic [NREQ-1:0]   arb_grant;
    logic [GW-1:0]     arb_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              handshake;
    logic              in_range;
    logic              block;
    logic              req_we_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_data_q;

    osd_rr_arbiter #(.N(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (last_grant),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign req_ready = block ? '0 : arb_grant;
    assign handshake = |req_ready;
    assign sel_addr  = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
    assign sel_data  = req_data[int'(arb_idx)*DATA_W +: DATA_W];
    assign in_range  = sel_addr < CELLS_A;

    // Out-of-range writes are consumed so the writer never stalls, but only flag an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GW'(NREQ-1);
            grant_id   <= '0;
            err_oob    <= 1'b0;
            req_we_q   <= 1'b0;
            req_addr_q <= '0;
            req_data_q <= '0;
        end else begin
            req_we_q <= handshake && in_range;
            if (handshake) begin
                last_grant <= arb_idx;
                grant_id   <= arb_idx;
                req_addr_q <= sel_addr;
                req_data_q <= sel_data;
                if (!in_range) begin
                    err_oob <= 1'b1;
                end
            end
        end
    end

`ifdef OSD_VRAM_ARBITER_CLEAR_EN
    localparam int CNT_W = $clog2(CELLS);

    clr_state_t        state;
    clr_state_t        state_next;
    logic [CNT_W-1:0]  clr_cnt;
    logic [DATA_W-1:0] clr_char_q;
    logic              clr_last;

    assign clr_last = clr_cnt == CNT_W'(CELLS-1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLR_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLR_IDLE: if (clear_start) state_next = CLR_RUN;
            CLR_RUN:  if (clr_last)    state_next = CLR_IDLE;
            default:  state_next = CLR_IDLE;
        endcase
    end

    always_comb begin
        clear_busy = 1'b0;
        case (state)
            CLR_RUN: clear_busy = 1'b1;
            default: clear_busy = 1'b0;
        endcase
    end

    // The counter is the address being written this cycle; it rests at zero between clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt    <= '0;
            clr_char_q <= '0;
        end else if (state == CLR_RUN) begin
            clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
        end else if (clear_start) begin
            clr_char_q <= clear_char;
        end
    end

    assign block     = rst | clear_busy | clear_start;
    assign v_we      = req_we_q | clear_busy;
    assign v_wr_addr = clear_busy ? ADDR_W'(clr_cnt) : req_addr_q;
    assign v_wr_data = clear_busy ? clr_char_q : req_data_q;
`else
    logic unused_clear;

    assign unused_clear = ^{clear_start, clear_char};
    assign clear_busy   = 1'b0;
    assign block        = rst;
    assign v_we         = req_we_q;
    assign v_wr_addr    = req_addr_q;
    assign v_wr_data    = req_data_q;
`endif
endmodule

// File: tb/tb_osd_vram_arbiter.sv
// Testbench for osd_vram_arbiter: directed vector table, clear-engine sequences
// and randomized traffic against a behavioural arbitration model.
module tb_osd_vram_arbiter;
    localparam int NREQ   = 4;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int CELLS  = 1200;
`ifdef OSD_VRAM_ARBITER_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic                              clk = 1'b0;
    logic                              rst;
    logic [NREQ-1:0]                   req_valid;
    logic [NREQ-1:0]                   req_ready;
    logic [NREQ-1:0][ADDR_W-1:0]       req_addr;
    logic [NREQ-1:0][DATA_W-1:0]       req_data;
    logic                              clear_start;
    logic [DATA_W-1:0]                 clear_char;
    logic                              clear_busy;
    logic [1:0]                        grant_id;
    logic                              err_oob;
    logic                              v_we;
    logic [ADDR_W-1:0]                 v_wr_addr;
    logic [DATA_W-1:0]                 v_wr_data;

    osd_vram_arbiter #(.NREQ(NREQ), .COLS(40), .ROWS(30), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .clear_start (clear_start),
        .clear_char  (clear_char),
        .clear_busy  (clear_busy),
        .grant_id    (grant_id),
        .err_oob     (err_oob),
        .v_we        (v_we),
        .v_wr_addr   (v_wr_addr),
        .v_wr_data   (v_wr_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: priority pointer, pending write, sticky error, clear progress.
    int m_ptr, m_gid, m_addr, m_data, clr_k, clr_char, last_win;
    bit m_oob, m_we, clr_active;

    typedef struct {
        logic [NREQ-1:0]             valid;
        logic [NREQ-1:0][ADDR_W-1:0] addr;
        logic [NREQ-1:0][DATA_W-1:0] data;
        logic [NREQ-1:0]             exp_ready;
        logic                        exp_we;
        logic [ADDR_W-1:0]           exp_addr;
        logic [DATA_W-1:0]           exp_data;
        logic [1:0]                  exp_gid;
        logic                        exp_oob;
    } vec_t;

    vec_t tbl[10];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = NREQ - 1; m_gid = 0; m_oob = 1'b0; m_we = 1'b0;
        m_addr = 0; m_data = 0; clr_active = 1'b0; clr_k = 0; clr_char = 0;
        last_win = -1;
    endtask

    function automatic int model_winner();
        if (rst || (CLEAR_EN && (clr_active || clear_start))) return -1;
        for (int i = 1; i <= NREQ; i++) begin
            if (req_valid[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic apply_stimulus(input logic [NREQ-1:0] v, input logic [NREQ-1:0][ADDR_W-1:0] a,
                                  input logic [NREQ-1:0][DATA_W-1:0] d, input logic cs, input logic [DATA_W-1:0] cc);
        req_valid   = v;
        req_addr    = a;
        req_data    = d;
        clear_start = cs;
        clear_char  = cc;
    endtask

    // One clock: compare DUT against the model mid-cycle, then advance the model across the edge.
    task automatic step();
        int win;
        logic [NREQ-1:0] exp_ready;
        @(negedge clk);
        win = model_winner();
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        check_output("req_ready", 64'(req_ready), 64'(exp_ready));
        check_output("clear_busy", 64'(clear_busy), 64'(clr_active));
        if (clr_active) begin
            check_output("clr_we", 64'(v_we), 64'd1);
            check_output("clr_addr", 64'(v_wr_addr), 64'(clr_k));
            check_output("clr_data", 64'(v_wr_data), 64'(clr_char));
        end else begin
            check_output("v_we", 64'(v_we), 64'(m_we));
            if (m_we) begin
                check_output("v_wr_addr", 64'(v_wr_addr), 64'(m_addr));
                check_output("v_wr_data", 64'(v_wr_data), 64'(m_data));
            end
        end
        check_output("grant_id", 64'(grant_id), 64'(m_gid));
        check_output("err_oob", 64'(err_oob), 64'(m_oob));
        if (rst) begin
            model_reset();
        end else begin
            m_we = 1'b0;
            if (win >= 0) begin
                m_ptr = win;
                m_gid = win;
                if (int'(req_addr[win]) < CELLS) begin
                    m_we = 1'b1; m_addr = int'(req_addr[win]); m_data = int'(req_data[win]);
                end else begin
                    m_oob = 1'b1;
                end
            end
            if (clr_active) begin
                clr_k++;
                if (clr_k == CELLS) clr_active = 1'b0;
            end else if (CLEAR_EN && clear_start) begin
                clr_active = 1'b1; clr_k = 0; clr_char = int'(clear_char);
            end
            last_win = win;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle();
        apply_stimulus('0, '0, '0, 1'b0, '0);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nwr, leak;
        logic [NREQ-1:0]             rv;
        logic [NREQ-1:0][ADDR_W-1:0] ra;
        logic [NREQ-1:0][DATA_W-1:0] rd;
        logic                        cs;

        tbl[0] = '{4'b0101, {16'h0, 16'h20, 16'h0, 16'h10}, {8'h0, 8'h42, 8'h0, 8'h41}, 4'b0001, 1'b0, 16'h0,   8'h0,  2'd0, 1'b0};
        tbl[1] = '{4'b0101, {16'h0, 16'h20, 16'h0, 16'h10}, {8'h0, 8'h42, 8'h0, 8'h41}, 4'b0100, 1'b1, 16'h10,  8'h41, 2'd0, 1'b0};
        tbl[2] = '{4'b0101, {16'h0, 16'h20, 16'h0, 16'h10}, {8'h0, 8'h42, 8'h0, 8'h41}, 4'b0001, 1'b1, 16'h20,  8'h42, 2'd2, 1'b0};
        tbl[3] = '{4'b0101, {16'h0, 16'h20, 16'h0, 16'h10}, {8'h0, 8'h42, 8'h0, 8'h41}, 4'b0100, 1'b1, 16'h10,  8'h41, 2'd0, 1'b0};
        tbl[4] = '{4'b1000, {16'h30, 16'h0, 16'h0, 16'h0},  {8'h43, 8'h0, 8'h0, 8'h0},  4'b1000, 1'b1, 16'h20,  8'h42, 2'd2, 1'b0};
        tbl[5] = '{4'b0010, {16'h0, 16'h0, 16'h31, 16'h0},  {8'h0, 8'h0, 8'h44, 8'h0},  4'b0010, 1'b1, 16'h30,  8'h43, 2'd3, 1'b0};
        tbl[6] = '{4'b0010, {16'h0, 16'h0, 16'h4B0, 16'h0}, {8'h0, 8'h0, 8'h55, 8'h0},  4'b0010, 1'b1, 16'h31,  8'h44, 2'd1, 1'b0};
        tbl[7] = '{4'b0000, {16'h0, 16'h0, 16'h0, 16'h0},   {8'h0, 8'h0, 8'h0, 8'h0},   4'b0000, 1'b0, 16'h0,   8'h0,  2'd1, 1'b1};
        tbl[8] = '{4'b0001, {16'h0, 16'h0, 16'h0, 16'h4AF}, {8'h0, 8'h0, 8'h0, 8'h66},  4'b0001, 1'b0, 16'h0,   8'h0,  2'd1, 1'b1};
        tbl[9] = '{4'b0000, {16'h0, 16'h0, 16'h0, 16'h0},   {8'h0, 8'h0, 8'h0, 8'h0},   4'b0000, 1'b1, 16'h4AF, 8'h66, 2'd0, 1'b1};

        apply_stimulus('0, '0, '0, 1'b0, '0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_output("rst_v_we", 64'(v_we), 64'd0);
        check_output("rst_v_wr_addr", 64'(v_wr_addr), 64'd0);
        check_output("rst_v_wr_data", 64'(v_wr_data), 64'd0);
        check_output("rst_req_ready", 64'(req_ready), 64'd0);
        check_output("rst_clear_busy", 64'(clear_busy), 64'd0);
        check_output("rst_grant_id", 64'(grant_id), 64'd0);
        check_output("rst_err_oob", 64'(err_oob), 64'd0);

        // Fairness, pointer hold and out-of-range vectors.
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(tbl[i].valid, tbl[i].addr, tbl[i].data, 1'b0, '0);
            #1;
            check_output($sformatf("tbl%0d_ready", i), 64'(req_ready), 64'(tbl[i].exp_ready));
            check_output($sformatf("tbl%0d_we", i), 64'(v_we), 64'(tbl[i].exp_we));
            if (tbl[i].exp_we) begin
                check_output($sformatf("tbl%0d_addr", i), 64'(v_wr_addr), 64'(tbl[i].exp_addr));
                check_output($sformatf("tbl%0d_data", i), 64'(v_wr_data), 64'(tbl[i].exp_data));
            end
            check_output($sformatf("tbl%0d_gid", i), 64'(grant_id), 64'(tbl[i].exp_gid));
            check_output($sformatf("tbl%0d_oob", i), 64'(err_oob), 64'(tbl[i].exp_oob));
            step();
        end
        reset_cycle();
        check_output("oob_cleared_by_rst", 64'(err_oob), 64'd0);

`ifdef OSD_VRAM_ARBITER_CLEAR_EN
        // Full clear with requester 0 waiting the whole time.
        apply_stimulus(4'b0001, {16'h0, 16'h0, 16'h0, 16'h5}, {8'h0, 8'h0, 8'h0, 8'h77}, 1'b1, 8'h20);
        #1;
        check_output("clr_start_blocks_ready", 64'(req_ready), 64'd0);
        step();
        clear_start = 1'b0;
        nwr = 0;
        leak = 0;
        for (int c = 0; c < CELLS + 100; c++) begin
            if (!clear_busy) break;
            if (v_we && int'(v_wr_addr) == nwr && v_wr_data == 8'h20) nwr++;
            if (req_ready != '0) leak++;
            step();
        end
        check_output("clr_write_count", 64'(nwr), 64'(CELLS));
        check_output("clr_ready_leak", 64'(leak), 64'd0);
        check_output("clr_busy_fell", 64'(clear_busy), 64'd0);
        check_output("clr_fall_accept", 64'(req_ready), 64'b0001);
        step();
        req_valid = '0;
        step();

        // Reset part-way through a clear, then restart from address 0.
        apply_stimulus('0, '0, '0, 1'b1, 8'h2A);
        step();
        clear_start = 1'b0;
        repeat (500) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_output("rst_mid_we", 64'(v_we), 64'd0);
        check_output("rst_mid_busy", 64'(clear_busy), 64'd0);
        clear_start = 1'b1;
        clear_char  = 8'h2B;
        step();
        clear_start = 1'b0;
        check_output("restart_first_write", 64'({v_we, v_wr_addr, v_wr_data}), 64'({1'b1, 16'h0, 8'h2B}));
        for (int c = 0; c < CELLS + 100; c++) begin
            if (!clear_busy) break;
            step();
        end
        check_output("restart_done", 64'(clear_busy), 64'd0);
`else
        // Without the clear engine a clear_start pulse must not disturb traffic.
        apply_stimulus(4'b0101, {16'h0, 16'h20, 16'h0, 16'h10}, {8'h0, 8'h42, 8'h0, 8'h41}, 1'b1, 8'h20);
        #1;
        check_output("noclr_ready", 64'(req_ready), 64'b0001);
        step();
        clear_start = 1'b0;
        check_output("noclr_busy", 64'(clear_busy), 64'd0);
        check_output("noclr_write", 64'({v_we, v_wr_addr}), 64'({1'b1, 16'h10}));
        repeat (3) step();
`endif

        // Randomized traffic with protocol-respecting requesters.
        reset_cycle();
        rv = '0;
        ra = '0;
        rd = '0;
        for (int it = 0; it < 800; it++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (!rv[r] || last_win == r) begin
                    rv[r] = ($urandom_range(0, 2) != 0);
                    case ($urandom_range(0, 9))
                        0: ra[r] = 16'(CELLS + $urandom_range(0, 300));
                        1: ra[r] = 16'(CELLS - 1);
                        default: ra[r] = 16'($urandom_range(0, CELLS - 1));
                    endcase
                    rd[r] = 8'($urandom);
                end
            end
            cs = CLEAR_EN ? ($urandom_range(0, 249) == 0) : ($urandom_range(0, 29) == 0);
            apply_stimulus(rv, ra, rd, cs, 8'($urandom));
            step();
        end
        apply_stimulus('0, '0, '0, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
